// File: rtl/sc_ifetch_pkg.sv
// Shared definitions for the single-cycle instruction fetch unit:
// next-PC select encodings, fetch FSM state type and the reset PC default.
package sc_ifetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Next-PC select values driven by the control unit
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JR     = 2'b10,
    PC_JUMP   = 2'b11
  } pcsource_t;

  // FETCH waits on instruction memory, HOLD waits on the core to retire
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_t;

  // Branch displacement: sign-extended word offset converted to bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/sc_ifetch_npc.sv
// Next-PC selector: purely combinational, all arithmetic wraps modulo 2^32.
module sc_npc
  import sc_ifetch_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic [31:0] ra_data,
  input  logic [1:0]  pcsource,
  output logic [31:0] next_pc
);

  // Select the successor address; jr targets are forced word-aligned
  always_comb begin
    next_pc = pc4;
    case (pcsource_t'(pcsource))
      PC_SEQ:    next_pc = pc4;
      PC_BRANCH: next_pc = pc4 + branch_offset(imm);
      PC_JR:     next_pc = ra_data & 32'hFFFF_FFFC;
      PC_JUMP:   next_pc = {pc4[31:28], target, 2'b00};
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_ifetch.sv
// Instruction fetch unit: fetches one word, holds it for the core until it
// retires, then advances the PC according to the control unit's select.
module sc_ifetch
  import sc_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        inst_ready,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra_data,
  output logic [31:0] retired
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  retired_q;
  logic [31:0]  next_pc;

  sc_npc u_npc (
    .pc4      (pc4),
    .imm      (inst_q[15:0]),
    .target   (inst_q[25:0]),
    .ra_data  (ra_data),
    .pcsource (pcsource),
    .next_pc  (next_pc)
  );

  // Fetch/hold FSM with the PC, held instruction and retire counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0000;
      retired_q <= 32'h0000_0000;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            inst_q <= imem_rdata;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            pc_q      <= next_pc;
            retired_q <= retired_q + 32'd1;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Request is masked while reset is held so nothing is fetched during reset
  assign imem_req   = (state == ST_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign inst_valid = (state == ST_HOLD);
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign pc4        = pc_q + 32'd4;
  assign retired    = retired_q;

  // Decoded fields are plain slices of the held instruction
  assign op   = inst_q[31:26];
  assign rs   = inst_q[25:21];
  assign rt   = inst_q[20:16];
  assign rd   = inst_q[15:11];
  assign sa   = inst_q[10:6];
  assign func = inst_q[5:0];
  assign imm  = inst_q[15:0];

endmodule

// File: tb/tb_sc_ifetch.sv
// Self-checking bench for sc_ifetch: a table of fetch/retire transactions
// followed by hand-written stall, counter-wrap and reset-in-hold sequences.
module tb_sc_ifetch;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        inst_ready;
  logic [1:0]  pcsource;
  logic [31:0] ra_data;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  pcsource;
    logic [31:0] ra_data;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  sc_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .op         (op),
    .func       (func),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .sa         (sa),
    .imm        (imm),
    .pc         (pc),
    .pc4        (pc4),
    .inst_ready (inst_ready),
    .pcsource   (pcsource),
    .ra_data    (ra_data),
    .retired    (retired)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Advance one full clock and come back to the sampling (falling) edge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Zero-wait fetch: checks the request, returns the word, checks the hold
  task automatic apply_stimulus(input logic [31:0] rdata, input logic [31:0] exp_pc);
    check_output("fetch_req", {31'd0, imem_req}, 32'd1);
    check_output("fetch_addr", imem_addr, exp_pc);
    check_output("fetch_valid", {31'd0, inst_valid}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    check_output("hold_valid", {31'd0, inst_valid}, 32'd1);
    check_output("hold_req", {31'd0, imem_req}, 32'd0);
    check_output("hold_inst", inst, rdata);
    check_output("hold_pc", pc, exp_pc);
    check_output("hold_pc4", pc4, exp_pc + 32'd4);
  endtask

  // Retire the held instruction with the given next-PC select
  task automatic retire_one(input logic [1:0] sel, input logic [31:0] ra);
    inst_ready = 1'b1;
    pcsource   = sel;
    ra_data    = ra;
    step();
    inst_ready = 1'b0;
    pcsource   = 2'b00;
    ra_data    = 32'h0;
  endtask

  initial begin
    logic [31:0] v;

    vecs[0]  = '{32'h0000_0000, 2'b00, 32'h0,         32'h0000_0000};
    vecs[1]  = '{32'h8C22_0010, 2'b00, 32'h0,         32'h0000_0004};
    vecs[2]  = '{32'h0064_2820, 2'b00, 32'h0,         32'h0000_0008};
    vecs[3]  = '{32'h03E0_0008, 2'b10, 32'h0000_0103, 32'h0000_000C};
    vecs[4]  = '{32'h1000_FFFF, 2'b01, 32'h0,         32'h0000_0100};
    vecs[5]  = '{32'h0000_0000, 2'b10, 32'h0000_2003, 32'h0000_0100};
    vecs[6]  = '{32'h0000_0000, 2'b10, 32'h0000_1000, 32'h0000_2000};
    vecs[7]  = '{32'h0800_0040, 2'b11, 32'h0,         32'h0000_1000};
    vecs[8]  = '{32'h0000_0000, 2'b10, 32'hFFFF_FFFF, 32'h0000_0100};
    vecs[9]  = '{32'h0000_0000, 2'b00, 32'h0,         32'hFFFF_FFFC};
    vecs[10] = '{32'h1000_0010, 2'b01, 32'h0,         32'h0000_0000};
    vecs[11] = '{32'h1000_8000, 2'b01, 32'h0,         32'h0000_0044};
    vecs[12] = '{32'h0123_4567, 2'b00, 32'h0,         32'hFFFE_0048};

    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b1;
    pcsource   = 2'b11;
    ra_data    = 32'h0;

    // Reset with memory and core strobes active: everything must be ignored
    step();
    step();
    check_output("rst_req", {31'd0, imem_req}, 32'd0);
    check_output("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_output("rst_addr", imem_addr, 32'h0);
    check_output("rst_inst", inst, 32'h0);
    check_output("rst_retired", retired, 32'h0);
    imem_ready = 1'b0;
    inst_ready = 1'b0;
    pcsource   = 2'b00;
    imem_rdata = 32'h0;
    reset      = 1'b0;
    @(posedge clock);
    #1;
    check_output("post_rst_req", {31'd0, imem_req}, 32'd1);
    @(negedge clock);

    // Table of zero-wait transactions, two cycles per instruction
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].rdata, vecs[i].exp_pc);
      v = vecs[i].rdata;
      check_output("dec_op", {26'd0, op}, {26'd0, v[31:26]});
      check_output("dec_rs", {27'd0, rs}, {27'd0, v[25:21]});
      check_output("dec_rt", {27'd0, rt}, {27'd0, v[20:16]});
      check_output("dec_rd", {27'd0, rd}, {27'd0, v[15:11]});
      check_output("dec_sa", {27'd0, sa}, {27'd0, v[10:6]});
      check_output("dec_func", {26'd0, func}, {26'd0, v[5:0]});
      check_output("dec_imm", {16'd0, imm}, {16'd0, v[15:0]});
      retire_one(vecs[i].pcsource, vecs[i].ra_data);
      check_output("tbl_retired", retired, 32'(i + 1));
    end
    check_output("tbl_last_addr", imem_addr, 32'hFFFE_004C);

    // Memory stall of 5 cycles; inst_ready during FETCH is ignored
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("stall_addr", imem_addr, 32'hFFFE_004C);
      check_output("stall_req", {31'd0, imem_req}, 32'd1);
      check_output("stall_valid", {31'd0, inst_valid}, 32'd0);
      check_output("stall_retired", retired, 32'd13);
    end
    inst_ready = 1'b0;
    apply_stimulus(32'hAC85_0008, 32'hFFFE_004C);

    // Core stall of 3 cycles; imem_ready without a request is ignored
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("hold_stall_inst", inst, 32'hAC85_0008);
      check_output("hold_stall_pc", pc, 32'hFFFE_004C);
      check_output("hold_stall_rt", {27'd0, rt}, 32'd5);
      check_output("hold_stall_valid", {31'd0, inst_valid}, 32'd1);
      check_output("hold_stall_retired", retired, 32'd13);
    end
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    retire_one(2'b00, 32'h0);
    check_output("stall_retire_cnt", retired, 32'd14);
    check_output("stall_next_addr", imem_addr, 32'hFFFE_0050);

    // Retire counter wrap: preload near the top while idle in FETCH
    force dut.retired_q = 32'hFFFF_FFFE;
    step();
    release dut.retired_q;
    step();
    check_output("wrap_preload", retired, 32'hFFFF_FFFE);
    apply_stimulus(32'h0000_0000, 32'hFFFE_0050);
    retire_one(2'b00, 32'h0);
    check_output("wrap_max", retired, 32'hFFFF_FFFF);
    apply_stimulus(32'h0000_0000, 32'hFFFE_0054);
    retire_one(2'b00, 32'h0);
    check_output("wrap_zero", retired, 32'h0);

    // Reset while holding with a coincident retire request
    apply_stimulus(32'h0800_0040, 32'hFFFE_0058);
    reset      = 1'b1;
    inst_ready = 1'b1;
    pcsource   = 2'b11;
    step();
    check_output("rsth_req", {31'd0, imem_req}, 32'd0);
    check_output("rsth_valid", {31'd0, inst_valid}, 32'd0);
    check_output("rsth_pc", pc, 32'h0);
    check_output("rsth_inst", inst, 32'h0);
    check_output("rsth_retired", retired, 32'h0);
    reset      = 1'b0;
    inst_ready = 1'b0;
    pcsource   = 2'b00;
    step();
    check_output("rsth_rel_addr", imem_addr, 32'h0);
    check_output("rsth_rel_req", {31'd0, imem_req}, 32'd1);
    check_output("rsth_rel_retired", retired, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
